// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the mode-selectable counter sequencer.
//  - Mode codes driven on the counter's 2-bit select.
//  - Scheduler state encoding and the enum built on it.
package counter_ctrl_pkg;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;
  localparam logic [1:0] MODE_ODD  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider for the count-enable tick.
// Ports:
//   clk   in  system clock
//   Clear in  async active-high reset (counter to 0)
//   en    in  advance the divider this cycle; low freezes it
//   clr   in  synchronous clear to 0 (wins over en)
//   tick  out combinational strobe: en is high and the divider sits at
//             DIV-1, i.e. this edge wraps it. The owner registers it.
module tick_prescaler #(
  parameter int DIV   = 100000000,
  parameter int DIV_W = 27
) (
  input  logic clk,
  input  logic Clear,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Independent of clr so the owner may derive clr from tick without a loop.
  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_mode_scheduler.sv
// Sequencer for the mode-selectable 4-bit counter datapath. Emits a
// one-cycle count-enable tick every DIV clocks while running and rotates
// the mode select round-robin through the enabled modes, dwelling
// TICKS_PER_MODE ticks in each. All outputs are registered.
// Ports:
//   clk       in  system clock
//   Clear     in  async active-high reset
//   start     in  pulse: IDLE->LOAD, or resume PAUSE->RUN
//   stop      in  pulse: RUN->PAUSE, or abort PAUSE->IDLE (beats start)
//   mode_mask in  bit i set = mode code i is in the rotation
//   tick      out one-cycle count enable
//   sel       out current mode code
//   run       out high while in RUN
//   mode_done out pulse on the tick that closes a dwell
module counter_mode_scheduler
  import counter_ctrl_pkg::*;
#(
  parameter int DIV            = 100000000,
  parameter int DIV_W          = 27,
  parameter int TICKS_PER_MODE = 8,
  parameter int TPM_W          = 4
) (
  input  logic       clk,
  input  logic       Clear,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mode_mask,
  output logic       tick,
  output logic [1:0] sel,
  output logic       run,
  output logic       mode_done
);

  localparam logic [TPM_W-1:0] LAST_TICK = TPM_W'(TICKS_PER_MODE - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [TPM_W-1:0] tcnt_q, tcnt_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic             pre_en, pre_clr, pre_wrap;
  logic [1:0]       low_sel, nxt_sel;
  logic             mask_any;

  tick_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_pre (
    .clk   (clk),
    .Clear (Clear),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_wrap)
  );

  assign mask_any = (mode_mask != 4'b0000);

  // Lowest enabled mode, used when entering the rotation.
  always_comb begin
    low_sel = MODE_ZERO;
    for (int k = 3; k >= 0; k--)
      if (mode_mask[k]) low_sel = 2'(k);
  end

  // Next enabled mode after sel_q, searching sel+1 .. sel+4 (mod 4).
  // Scanned farthest-first so the nearest hit overwrites; sel+4 is sel
  // itself, which keeps a single-mode mask parked on its code.
  always_comb begin
    nxt_sel = sel_q;
    for (int k = 4; k >= 1; k--)
      if (mode_mask[2'(sel_q + 2'(k))]) nxt_sel = 2'(sel_q + 2'(k));
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tcnt_d  = tcnt_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_d   = MODE_ZERO;
        tcnt_d  = '0;
        pre_clr = 1'b1;
        if (start && !stop && mask_any) state_d = S_LOAD;
      end
      S_LOAD: begin
        tcnt_d  = '0;
        pre_clr = 1'b1;
        if (mask_any) begin
          sel_d   = low_sel;
          state_d = S_RUN;
        end else begin
          sel_d   = MODE_ZERO;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          // Freeze everything on the stop edge, including a pending wrap.
          state_d = S_PAUSE;
        end else begin
          pre_en = 1'b1;
          if (pre_wrap) begin
            if (tcnt_q == LAST_TICK) begin
              tcnt_d = '0;
              if (mask_any) begin
                sel_d  = nxt_sel;
                tick_d = 1'b1;
                done_d = 1'b1;
              end else begin
                // Rotation emptied: drop to IDLE; tick/done stay low so
                // they never appear outside RUN.
                sel_d   = MODE_ZERO;
                state_d = S_IDLE;
              end
            end else begin
              tcnt_d = tcnt_q + TPM_W'(1);
              tick_d = 1'b1;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          sel_d   = MODE_ZERO;
          tcnt_d  = '0;
          pre_clr = 1'b1;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      sel_q   <= MODE_ZERO;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign tick      = tick_q;
  assign sel       = sel_q;
  assign run       = run_q;
  assign mode_done = done_q;

endmodule

// File: tb/tb_counter_mode_scheduler.sv
// Scoreboarded bench: stimulus steps a time-based reference model and
// queues the expected outputs for each clock edge; a monitor pops and
// compares one entry per edge.
module tb_counter_mode_scheduler;
  localparam int DIV = 4, DIV_W = 3, TPM = 3, TPM_W = 2;

  logic       clk = 1'b0;
  logic       Clear, start, stop;
  logic [3:0] mode_mask, rmask;
  logic       tick, run, mode_done;
  logic [1:0] sel;

  counter_mode_scheduler #(
    .DIV(DIV), .DIV_W(DIV_W), .TICKS_PER_MODE(TPM), .TPM_W(TPM_W)
  ) dut (
    .clk(clk), .Clear(Clear), .start(start), .stop(stop),
    .mode_mask(mode_mask), .tick(tick), .sel(sel), .run(run),
    .mode_done(mode_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic [1:0] sel;
    logic       run;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  // Reference model: whether a sequence is active/paused/loading, the
  // number of clocks spent running since the load, and the current mode.
  bit   m_active, m_paused, m_loading, m_tick;
  int   m_sel, m_run_cycles;

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_enabled(input logic [3:0] m, input int cur);
    for (int d = 1; d <= 4; d++) if (m[(cur + d) % 4]) return (cur + d) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_loading = 0; m_sel = 0; m_run_cycles = 0;
    m_tick = 0;
  endtask

  task automatic mstep(input bit s, input bit p, input logic [3:0] m);
    obs_t e;
    e = '0;
    if (m_loading) begin
      m_loading = 0;
      if (m != 0) begin m_active = 1; m_sel = lowest(m); m_run_cycles = 0; end
      else m_sel = 0;
    end else if (!m_active) begin
      m_sel = 0;
      if (s && !p && m != 0) m_loading = 1;
    end else if (m_paused) begin
      if (p) begin m_active = 0; m_paused = 0; m_sel = 0; end
      else if (s) m_paused = 0;
    end else if (p) begin
      m_paused = 1;
    end else begin
      m_run_cycles++;
      if (m_run_cycles % DIV == 0) begin
        if ((m_run_cycles / DIV) % TPM == 0) begin
          if (m == 0) begin m_active = 0; m_sel = 0; end
          else begin e.tick = 1; e.done = 1; m_sel = next_enabled(m, m_sel); end
        end else e.tick = 1;
      end
    end
    e.sel = 2'(m_sel);
    e.run = m_active && !m_paused && !m_loading;
    m_tick = e.tick;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit p, input logic [3:0] m);
    @(negedge clk);
    start = s; stop = p; mode_mask = m;
    mstep(s, p, m);
  endtask

  task automatic idle(input int n, input logic [3:0] m);
    for (int i = 0; i < n; i++) cyc(0, 0, m);
  endtask

  task automatic abort_seq(input logic [3:0] m);
    cyc(0, 1, m);
    cyc(0, 1, m);
    idle(2, m);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {tick, sel, run, mode_done};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got tick=%b sel=%b run=%b done=%b want tick=%b sel=%b run=%b done=%b",
                   $time, a.tick, a.sel, a.run, a.done, e.tick, e.sel, e.run, e.done);
        end
      end
    end
  end

  initial begin
    Clear = 1'b1; start = 0; stop = 0; mode_mask = 4'h0; rmask = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_tick", {31'd0, tick}, 0);
    chk("reset_sel", {30'd0, sel}, 0);
    chk("reset_run", {31'd0, run}, 0);
    chk("reset_done", {31'd0, mode_done}, 0);
    Clear = 1'b0;

    // Basic full rotation
    cyc(1, 0, 4'hF);
    idle(60, 4'hF);
    abort_seq(4'hF);

    // Sparse mask 1010
    cyc(1, 0, 4'hA);
    idle(50, 4'hA);
    abort_seq(4'hA);

    // Single mode 0100
    cyc(1, 0, 4'h4);
    idle(40, 4'h4);
    abort_seq(4'h4);

    // Pause / resume, then abort from pause
    cyc(1, 0, 4'hF);
    for (int i = 0; i < 50 && !m_tick; i++) cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 1, 4'hF);
    idle(20, 4'hF);
    cyc(1, 0, 4'hF);
    idle(10, 4'hF);
    cyc(0, 1, 4'hF);
    idle(3, 4'hF);
    cyc(0, 1, 4'hF);
    idle(3, 4'hF);

    // Start and stop together from IDLE
    cyc(1, 1, 4'hF);
    idle(5, 4'hF);

    // Mask cleared mid-RUN
    cyc(1, 0, 4'hF);
    idle(5, 4'hF);
    idle(40, 4'h0);

    // Start with empty mask
    cyc(1, 0, 4'h0);
    idle(5, 4'h0);

    // Clear pulsed mid-RUN while sel=10
    cyc(1, 0, 4'hF);
    for (int i = 0; i < 100 && m_sel != 2; i++) cyc(0, 0, 4'hF);
    @(posedge clk); #2;
    chk("pre_clear_sel", {30'd0, sel}, 2);
    Clear = 1'b1;
    #1;
    chk("clear_tick", {31'd0, tick}, 0);
    chk("clear_sel", {30'd0, sel}, 0);
    chk("clear_run", {31'd0, run}, 0);
    chk("clear_done", {31'd0, mode_done}, 0);
    @(negedge clk);
    Clear = 1'b0;
    model_reset();
    idle(10, 4'hF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rmask = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, rmask);
    end

    idle(2, rmask);
    @(posedge clk); #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
